pipa_moding_scheduler: RTL
==========================

# pipa_moding_scheduler

Generates the six PIPA inputs (PIPAXp/m, PIPAYp/m, PIPAZp/m) for the FPGA AGC from its PIPDAT/PIPASW outputs. Replaces the fixed 3-3 moding counter with a per-axis programmable moding pattern, so a bench or host can command simulated acceleration. Accepts new per-axis deltas through a valid/ready handshake and applies them atomically at moding-frame boundaries. Sits between `fpga_agc` outputs PIPASW/PIPDAT and its PIPA inputs, clocked by the 51.2 MHz SIM_CLK.

## Interface
Parameters:
- FRAME_CNT_W, 16, width of frame counter.

Ports:
- SIM_CLK  in  1  51.2 MHz simulation clock; only clock.
- SIM_RST  in  1  reset; synchronous, active-low.
- PIPASW  in  1  AGC PIPA switch strobe; asynchronous to SIM_CLK.
- PIPDAT  in  1  AGC PIPA data strobe; asynchronous to SIM_CLK.
- cfg_valid  in  1  new delta set offered.
- cfg_ready  out  1  scheduler can accept a delta set.
- cfg_dx, cfg_dy, cfg_dz  in  3 each  signed per-axis delta, two's complement.
- PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm  out  1 each  PIPA pulses to AGC.
- frame_count  out  FRAME_CNT_W  completed moding frames, wrapping.
- slot  out  3  current slot, 0..5.

## Operation
- PIPASW and PIPDAT each pass through a 2-flop synchronizer; rising edges are detected on the synchronized copies.
- Slot counter: a PIPASW rising edge advances slot by 1. The slot after 5 is 0, and that transition is the frame boundary.
- Per-axis plus count: P = 3 + d, where d is the active delta clamped to [-3,+3]. Encoded -4 clamps to -3.
- While slot < P, the axis drives its p output. Otherwise it drives its m output. Only the synchronized PIPDAT level passes to the output.
- Net count per frame is 2d. With d = 0 the pattern is exactly the legacy 3-3 moding.
- Handshake and pending register:
  - A transfer occurs when cfg_valid && cfg_ready. The three deltas are latched into a pending register and cfg_ready drops.
  - At the next frame boundary, pending becomes active and frame_count increments in the same cycle. cfg_ready returns high the following cycle.
  - At most one set is pending. With no PIPASW activity, pending stays indefinitely.
- Frame boundary without pending: active deltas are unchanged and frame_count still increments. frame_count wraps at 2^FRAME_CNT_W.
- Simultaneous PIPASW and PIPDAT edges in one cycle: the output uses the slot value before the increment.
- Reset values:
  - PIPA* = 0, slot = 0, frame_count = 0.
  - Active and pending deltas = 0, pending empty, cfg_ready = 1.
  - Synchronizer flops = 0.
- A mid-frame reset discards pending and abandons the partial frame. The first PIPASW edge after reset moves slot to 1.

## Timing
- PIPDAT pin to PIPA* output: 3 SIM_CLK (2 synchronizer + 1 output register). Pulse width equals the synchronized PIPDAT width.
- PIPASW pin to slot update: 3 SIM_CLK.
- Transfer to cfg_ready low: 1 cycle.
- Boundary edge detect to new pattern active: same cycle as the slot update.
- cfg_ready is not combinationally dependent on cfg_valid.

## Configuration
- PIPA_FAIL_INJECT_EN:
  - Defined: adds input `fail_mask` [2:0] (bit0 X, bit1 Y, bit2 Z). A masked axis drives both p and m on every PIPDAT pulse, an illegal pattern that exercises the AGC PIPA-fail alarm. The mask is sampled each cycle without synchronization.
  - Undefined: the port is absent and behaviour is identical to mask = 0.

## Structure
- Package `agc_pipa_pkg`:
  - Constants SLOTS_PER_FRAME = 6 and NOMINAL_PLUS = 3.
  - Typedef `pipa_delta_t` (signed 3-bit).
  - Clamp function.
- Sub-module `pipa_axis_sel`, instantiated ×3:
  - Inputs: slot, delta, PIPDAT_sync, and fail bit when enabled.
  - Outputs: registered p/m.
- The top holds the synchronizers, slot/frame counters and handshake/pending logic.

## Test plan
- Reset, then 12 PIPASW edges each followed by a PIPDAT pulse, deltas 0 → per axis exactly 3 p then 3 m per frame; frame_count = 2.
- Offer dx = +2, dy = -1, dz = 0 mid-frame → cfg_ready low 1 cycle after transfer. The current frame stays 3-3. Next frame gives X 5p/1m, Y 2p/4m, Z 3p/3m; cfg_ready high 1 cycle after the boundary.
- Offer dx = -4 (encoded 100) → X emits 0 p and 6 m per frame.
- Hold cfg_valid with no PIPASW activity → exactly one transfer; cfg_ready stays low and PIPA outputs stay 0.
- Assert SIM_RST low mid-frame with a set pending → all outputs 0, slot 0, cfg_ready 1. The next frame is 3-3.
- With PIPA_FAIL_INJECT_EN defined and fail_mask = 3'b010 → on each PIPDAT pulse PIPAYp = PIPAYm = 1; X and Z unaffected.

Source files
------------

// File: rtl/agc_pipa_pkg.sv
// Shared types and constants for the PIPA moding scheduler.
// Optional feature macro used by the design: PIPA_FAIL_INJECT_EN.
package agc_pipa_pkg;

    localparam int SLOTS_PER_FRAME = 6;
    localparam int NOMINAL_PLUS    = 3;

    typedef logic [2:0]        pipa_slot_t;
    typedef logic signed [2:0] pipa_delta_t;

    typedef struct packed {
        pipa_delta_t dx;
        pipa_delta_t dy;
        pipa_delta_t dz;
    } pipa_delta_set_t;

    // Limit a delta to [-3,+3]; the only out-of-range code is -4.
    function automatic pipa_delta_t clamp_delta(input pipa_delta_t d);
        return (d == 3'b100) ? 3'b101 : d;
    endfunction

    // Number of plus slots in a frame for a given delta (0..6).
    function automatic pipa_slot_t plus_count(input pipa_delta_t d);
        return pipa_slot_t'(NOMINAL_PLUS + int'(clamp_delta(d)));
    endfunction

endpackage

// File: rtl/pipa_axis_sel.sv
// Per-axis p/m selector: routes the synchronized PIPDAT level to the plus or
// minus output depending on where the slot falls in the axis moding pattern.
// Optional feature macro: PIPA_FAIL_INJECT_EN (adds the fail input).
module pipa_axis_sel
    import agc_pipa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  pipa_slot_t  slot,
    input  pipa_delta_t delta,
    input  logic        pipdat_sync,
`ifdef PIPA_FAIL_INJECT_EN
    input  logic        fail,
`endif
    output logic        pipa_p,
    output logic        pipa_m
);

    logic in_plus;
    logic fail_en;

    // Decide whether the current slot belongs to the plus part of the frame.
    always_comb begin
        in_plus = (slot < plus_count(delta));
`ifdef PIPA_FAIL_INJECT_EN
        fail_en = fail;
`else
        fail_en = 1'b0;
`endif
    end

    // Register the gated PIPDAT level onto p or m (both when failing).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipa_p <= 1'b0;
            pipa_m <= 1'b0;
        end else begin
            pipa_p <= pipdat_sync & (in_plus | fail_en);
            pipa_m <= pipdat_sync & (~in_plus | fail_en);
        end
    end

endmodule

// File: rtl/pipa_moding_scheduler.sv
// PIPA moding scheduler: synchronizes the AGC PIPASW/PIPDAT strobes, counts
// slots and frames, and applies host-supplied per-axis deltas atomically at
// frame boundaries through a one-deep pending register.
// Optional feature macro: PIPA_FAIL_INJECT_EN (adds fail_mask input).
module pipa_moding_scheduler
    import agc_pipa_pkg::*;
#(
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   SIM_CLK,
    input  logic                   SIM_RST,
    input  logic                   PIPASW,
    input  logic                   PIPDAT,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [2:0]             cfg_dx,
    input  logic [2:0]             cfg_dy,
    input  logic [2:0]             cfg_dz,
`ifdef PIPA_FAIL_INJECT_EN
    input  logic [2:0]             fail_mask,
`endif
    output logic                   PIPAXp,
    output logic                   PIPAXm,
    output logic                   PIPAYp,
    output logic                   PIPAYm,
    output logic                   PIPAZp,
    output logic                   PIPAZm,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [2:0]             slot
);

    localparam pipa_slot_t LAST_SLOT = pipa_slot_t'(SLOTS_PER_FRAME - 1);

    logic            sw_meta, sw_sync, sw_sync_d;
    logic            dat_meta, dat_sync;
    logic            sw_rise;
    logic            frame_boundary;
    logic            xfer;
    logic            pending_full;
    pipa_delta_set_t pending;
    pipa_delta_set_t active;

    assign sw_rise        = sw_sync & ~sw_sync_d;
    assign frame_boundary = sw_rise && (slot == LAST_SLOT);
    assign cfg_ready      = ~pending_full;
    assign xfer           = cfg_valid & ~pending_full;

    // Two-flop synchronizers plus one delay stage for PIPASW edge detection.
    always_ff @(posedge SIM_CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its source, keeping the chain a chain.
        if (!SIM_RST) begin
            sw_meta   <= 1'b0;
            sw_sync   <= 1'b0;
            sw_sync_d <= 1'b0;
            dat_meta  <= 1'b0;
            dat_sync  <= 1'b0;
        end else begin
            sw_meta   <= PIPASW;
            sw_sync   <= sw_meta;
            sw_sync_d <= sw_sync;
            dat_meta  <= PIPDAT;
            dat_sync  <= dat_meta;
        end
    end

    // Slot and frame counters advance on each synchronized PIPASW rise.
    always_ff @(posedge SIM_CLK) begin
        if (!SIM_RST) begin
            slot        <= '0;
            frame_count <= '0;
        end else if (sw_rise) begin
            slot <= (slot == LAST_SLOT) ? '0 : slot + 3'd1;
            if (frame_boundary) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

    // Accept one delta set into pending; promote it to active at a boundary.
    always_ff @(posedge SIM_CLK) begin
        // NOTE: the delta registers are reset too, because a reset must leave
        // the axes in legacy 3-3 moding rather than whatever was last loaded.
        if (!SIM_RST) begin
            pending_full <= 1'b0;
            pending      <= '0;
            active       <= '0;
        end else if (frame_boundary && pending_full) begin
            active       <= pending;
            pending_full <= 1'b0;
        end else if (xfer) begin
            pending      <= '{dx: cfg_dx, dy: cfg_dy, dz: cfg_dz};
            pending_full <= 1'b1;
        end
    end

    pipa_axis_sel u_axis_x (
        .clk         (SIM_CLK),
        .rst_n       (SIM_RST),
        .slot        (slot),
        .delta       (active.dx),
        .pipdat_sync (dat_sync),
`ifdef PIPA_FAIL_INJECT_EN
        .fail        (fail_mask[0]),
`endif
        .pipa_p      (PIPAXp),
        .pipa_m      (PIPAXm)
    );

    pipa_axis_sel u_axis_y (
        .clk         (SIM_CLK),
        .rst_n       (SIM_RST),
        .slot        (slot),
        .delta       (active.dy),
        .pipdat_sync (dat_sync),
`ifdef PIPA_FAIL_INJECT_EN
        .fail        (fail_mask[1]),
`endif
        .pipa_p      (PIPAYp),
        .pipa_m      (PIPAYm)
    );

    pipa_axis_sel u_axis_z (
        .clk         (SIM_CLK),
        .rst_n       (SIM_RST),
        .slot        (slot),
        .delta       (active.dz),
        .pipdat_sync (dat_sync),
`ifdef PIPA_FAIL_INJECT_EN
        .fail        (fail_mask[2]),
`endif
        .pipa_p      (PIPAZp),
        .pipa_m      (PIPAZm)
    );

endmodule
